// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the buffered 1-to-4 distributor
package demux_pkg;

    localparam int DEMUX_PORTS = 4;
    localparam int DEMUX_SEL_W = 2;
    localparam int DEMUX_WIDTH = 64;
    localparam int DEMUX_CNT_W = 16;

    typedef logic [DEMUX_SEL_W-1:0] slot_idx_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - single-entry holding register with load/drain/full interface
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    slot_state_t state;
    slot_state_t state_next;

    // State register; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a load always leaves the slot full, a drain without load empties it.
    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: if (load) state_next = SLOT_FULL;
            SLOT_FULL:  if (!load && ready) state_next = SLOT_EMPTY;
            default:    state_next = SLOT_EMPTY;
        endcase
    end

    // Data register only changes on a load, so a stalled word stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    assign full = (state == SLOT_FULL);

endmodule

// File: rtl/demux_4by64_buf.sv
// rtl/demux_4by64_buf.sv - buffered 1-to-4 word distributor; DEMUX_CNT_EN adds per-slot delivery counters
module demux_4by64_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = DEMUX_CNT_W
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DEMUX_SEL_W-1:0]       in_sel,
    input  logic [WIDTH-1:0]             in_data,
    output logic [DEMUX_PORTS-1:0]       out_valid,
    input  logic [DEMUX_PORTS-1:0]       out_ready,
`ifdef DEMUX_CNT_EN
    output logic [DEMUX_PORTS*WIDTH-1:0] out_data,
    input  logic                         cnt_clr,
    output logic [DEMUX_PORTS*CNT_W-1:0] out_cnt
`else
    output logic [DEMUX_PORTS*WIDTH-1:0] out_data
`endif
);

    logic [DEMUX_PORTS-1:0] full;
    logic [DEMUX_PORTS-1:0] load;
    logic [DEMUX_PORTS-1:0] drain;
    logic                   accept;

    // The selected slot can take a word if it is empty or is being drained this cycle.
    assign in_ready = ~full[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;
    assign drain    = full & out_ready;
    assign out_valid = full;

    for (genvar i = 0; i < DEMUX_PORTS; i++) begin : g_slot
        assign load[i] = accept & (in_sel == slot_idx_t'(i));

        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[i]),
            .load_data(in_data),
            .ready    (out_ready[i]),
            .full     (full[i]),
            .data     (out_data[i*WIDTH +: WIDTH])
        );

`ifdef DEMUX_CNT_EN
        logic [CNT_W-1:0] cnt;

        // Delivery counter; clear wins over a coincident drain, wraps naturally.
        always_ff @(posedge clk) begin
            if (rst || cnt_clr) begin
                cnt <= '0;
            end else if (drain[i]) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign out_cnt[i*CNT_W +: CNT_W] = cnt;
`endif
    end

`ifndef DEMUX_CNT_EN
    logic unused_drain;
    assign unused_drain = ^drain;
`endif

endmodule

// File: tb/tb_demux_4by64_buf.sv
// tb/tb_demux_4by64_buf.sv - directed self-checking bench for demux_4by64_buf; counter checks need DEMUX_CNT_EN
module tb_demux_4by64_buf;

    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_sel;
    logic [W-1:0]   in_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [4*W-1:0] out_data;
`ifdef DEMUX_CNT_EN
    localparam int CW = 4;
    logic            cnt_clr;
    logic [4*CW-1:0] out_cnt;
`endif

    int errors = 0;
    int checks = 0;

`ifdef DEMUX_CNT_EN
    demux_4by64_buf #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .cnt_clr(cnt_clr), .out_cnt(out_cnt)
    );
`else
    demux_4by64_buf #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4*W-1:0] obs, input logic [4*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_sel = 2'd1;
        in_data = 64'h5555_AAAA_5555_AAAA;
        out_ready = 4'hF;
`ifdef DEMUX_CNT_EN
        cnt_clr = 1'b0;
`endif
        tick();
        tick();
        chk("rst_valid", out_valid, 4'b0000);
        chk("rst_data", out_data, '0);
`ifdef DEMUX_CNT_EN
        chk("rst_cnt", out_cnt, '0);
`endif
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 4'h0;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("rst_ready_sel%0d", s), in_ready, 1'b1);
        end

        // basic routing to slot 2
        in_valid = 1'b1;
        in_sel = 2'd2;
        in_data = 64'hDEAD_BEEF_0000_0002;
        #1;
        chk("route_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("route_valid", out_valid, 4'b0100);
        chk("route_data", out_data, {64'h0, 64'hDEAD_BEEF_0000_0002, 64'h0, 64'h0});
        #1;
        chk("route_full_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data = 64'h1111_2222_3333_4444;
        tick();
        chk("route_hold_data", out_data[2*W +: W], 64'hDEAD_BEEF_0000_0002);
        in_valid = 1'b0;
        out_ready = 4'b0100;
        #1;
        chk("route_drain_ready", in_ready, 1'b1);
        tick();
        chk("route_drained", out_valid, 4'b0000);

        // same-slot streaming into slot 1
        out_ready = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_sel = 2'd1;
            in_data = 64'hC0DE_0000_0000_1000 + 64'(k);
            #1;
            chk($sformatf("stream_ready%0d", k), in_ready, 1'b1);
            tick();
            chk($sformatf("stream_valid%0d", k), out_valid, 4'b0010);
            chk($sformatf("stream_data%0d", k), out_data[W +: W], 64'hC0DE_0000_0000_1000 + 64'(k));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_empty", out_valid, 4'b0000);

        // independent backpressure on slots 0 and 3
        out_ready = 4'b0000;
        in_valid = 1'b1;
        in_sel = 2'd0;
        in_data = 64'hAAAA_0000_0000_0000;
        tick();
        in_sel = 2'd3;
        in_data = 64'hBBBB_0000_0000_0003;
        tick();
        in_valid = 1'b0;
        chk("bp_both_full", out_valid, 4'b1001);
        out_ready = 4'b1000;
        tick();
        chk("bp_slot3_drained", out_valid, 4'b0001);
        chk("bp_slot0_held", out_data[0 +: W], 64'hAAAA_0000_0000_0000);
        in_sel = 2'd0;
        #1;
        chk("bp_slot0_busy", in_ready, 1'b0);
        in_valid = 1'b1;
        in_sel = 2'd3;
        in_data = 64'hCCCC_0000_0000_0003;
        #1;
        chk("bp_slot3_ready", in_ready, 1'b1);
        tick();
        chk("bp_refill_valid", out_valid, 4'b1001);
        chk("bp_refill_data", out_data[3*W +: W], 64'hCCCC_0000_0000_0003);
        in_data = 64'hDDDD_0000_0000_0003;
        #1;
        chk("bp_pass_ready", in_ready, 1'b1);
        tick();
        chk("bp_pass_valid", out_valid, 4'b1001);
        chk("bp_pass_data", out_data[3*W +: W], 64'hDDDD_0000_0000_0003);
        chk("bp_slot0_still", out_data[0 +: W], 64'hAAAA_0000_0000_0000);

        // in_valid low must not disturb any slot
        in_valid = 1'b0;
        out_ready = 4'b0000;
        in_sel = 2'd1;
        in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        chk("idle_valid", out_valid, 4'b1001);

        // reset with all four slots full
        in_valid = 1'b1;
        in_sel = 2'd1;
        in_data = 64'h1;
        tick();
        in_sel = 2'd2;
        in_data = 64'h2;
        tick();
        chk("mid_all_full", out_valid, 4'b1111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", out_valid, 4'b0000);
        chk("mid_rst_data", out_data, '0);
`ifdef DEMUX_CNT_EN
        chk("mid_rst_cnt", out_cnt, '0);
`endif
        out_ready = 4'hF;
        tick();
        chk("mid_no_stale", out_valid, 4'b0000);

`ifdef DEMUX_CNT_EN
        // counter wrap after 17 drains from slot 0
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        out_ready = 4'b0001;
        for (int k = 0; k < 17; k++) begin
            in_valid = 1'b1;
            in_sel = 2'd0;
            in_data = 64'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("cnt_wrap", out_cnt, 16'h0001);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr_priority", out_cnt, 16'h0000);
        chk("cnt_clr_drained", out_valid, 4'b0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
